// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART TX scheduler.
`default_nettype none

package uart_defines;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND_RES  = 2'd1,
      SEND_WORD = 2'd2
   } tx_sched_state_t;

   typedef enum logic {
      GRANT_RES   = 1'b0,
      GRANT_PRINT = 1'b1
   } tx_grant_t;

   localparam int UART_BYTES_PER_WORD = 4;
   localparam int UART_BYTE_CNT_W     = $clog2(UART_BYTES_PER_WORD);

endpackage

`default_nettype wire

// File: rtl/uart_tx_sched_if.sv
// Response, print and PHY-side handshake bundle of the UART TX scheduler.
`default_nettype none

interface uart_tx_sched_if;
   logic        res_req;
   logic [7:0]  res_byte;
   logic        res_ready;
   logic        print_en;
   logic [31:0] print_data;
   logic        print_full;
   logic        print_ovf;
   logic        tx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        busy;

   modport master (
      output res_req, res_byte, print_en, print_data, tx_ready,
      input  res_ready, print_full, print_ovf, tx_data, tx_valid, busy
   );

   modport slave (
      input  res_req, res_byte, print_en, print_data, tx_ready,
      output res_ready, print_full, print_ovf, tx_data, tx_valid, busy
   );
endinterface

`default_nettype wire

// File: rtl/uart_tx_sched_word_fifo.sv
// Synchronous word FIFO; the caller guarantees push/pop are legal.
`default_nettype none

module uart_word_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  wire logic                     clk,
   input  wire logic                     rstn,
   input  wire logic                     push,
   input  wire logic                     pop,
   input  wire logic [WIDTH-1:0]         din,
   output logic      [WIDTH-1:0]         dout,
   output logic                          full,
   output logic                          empty,
   output logic      [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; only pointers define validity.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx_sched.sv
// Arbitrates the UART TX PHY between held response bytes and 4-byte print words.
`default_nettype none

module uart_tx_sched
   import uart_defines::*;
#(
   parameter int PRINT_DEPTH = 8
) (
   input  wire logic        clk,
   input  wire logic        rstn,
   uart_tx_sched_if.slave   bus
);
   localparam int CW = $clog2(PRINT_DEPTH);

   tx_sched_state_t             state_q, state_d;
   tx_grant_t                   last_grant_q, last_grant_d;
   logic                        res_full_q, res_full_d;
   logic [7:0]                  res_byte_q, res_byte_d;
   logic [31:0]                 shift_q, shift_d;
   logic [UART_BYTE_CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
   logic                        ovf_q, ovf_d;

   logic                        fifo_push;
   logic                        fifo_pop;
   logic [31:0]                 fifo_dout;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [CW:0]                 fifo_count;
   logic                        tx_valid;
   logic [7:0]                  tx_data;

   // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
   assign fifo_push = bus.print_en && (!fifo_full || fifo_pop);
   assign ovf_d     = ovf_q || (bus.print_en && fifo_full && !fifo_pop);

   uart_word_fifo #(
      .WIDTH (32),
      .DEPTH (PRINT_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (bus.print_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_PRINT;
         res_full_q   <= 1'b0;
         res_byte_q   <= '0;
         shift_q      <= '0;
         byte_cnt_q   <= '0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         res_full_q   <= res_full_d;
         res_byte_q   <= res_byte_d;
         shift_q      <= shift_d;
         byte_cnt_q   <= byte_cnt_d;
         ovf_q        <= ovf_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      res_full_d   = res_full_q;
      res_byte_d   = res_byte_q;
      shift_d      = shift_q;
      byte_cnt_d   = byte_cnt_q;
      fifo_pop     = 1'b0;
      tx_valid     = 1'b0;
      tx_data      = '0;

      if (bus.res_req && !res_full_q) begin
         res_full_d = 1'b1;
         res_byte_d = bus.res_byte;
      end

      unique case (state_q)
         IDLE: begin
            // Response wins unless it won last time and a word is waiting.
            if (res_full_q && (fifo_empty || last_grant_q == GRANT_PRINT)) begin
               state_d      = SEND_RES;
               last_grant_d = GRANT_RES;
            end else if (!fifo_empty) begin
               fifo_pop     = 1'b1;
               shift_d      = fifo_dout;
               byte_cnt_d   = '0;
               state_d      = SEND_WORD;
               last_grant_d = GRANT_PRINT;
            end
         end
         SEND_RES: begin
            tx_valid = 1'b1;
            tx_data  = res_byte_q;
            if (bus.tx_ready) begin
               res_full_d = 1'b0;
               state_d    = IDLE;
            end
         end
         SEND_WORD: begin
            tx_valid = 1'b1;
            tx_data  = shift_q[7:0];
            if (bus.tx_ready) begin
               shift_d    = shift_q >> 8;
               byte_cnt_d = byte_cnt_q + UART_BYTE_CNT_W'(1);
               if (byte_cnt_q == UART_BYTE_CNT_W'(UART_BYTES_PER_WORD - 1))
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.tx_valid   = tx_valid;
   assign bus.tx_data    = tx_data;
   assign bus.res_ready  = !res_full_q;
   assign bus.print_full = fifo_full;
   assign bus.print_ovf  = ovf_q;
   assign bus.busy       = (state_q != IDLE) || (fifo_count != '0) || res_full_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
// Directed plus randomized bench for uart_tx_sched against a queue-based reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_sched;
   localparam int DEPTH = 8;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   uart_tx_sched_if u_if ();

   uart_tx_sched #(.PRINT_DEPTH(DEPTH)) u_dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (u_if)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: FIFO contents, bytes of the group on the wire, held response.
   logic [31:0] m_fifo [$];
   logic [7:0]  m_cur  [$];
   bit          m_cur_res;
   bit          m_res_pend;
   logic [7:0]  m_res_byte;
   bit          m_last_print;
   bit          m_ovf;

   task automatic model_reset();
      m_fifo.delete();
      m_cur.delete();
      m_cur_res    = 0;
      m_res_pend   = 0;
      m_res_byte   = '0;
      m_last_print = 1;
      m_ovf        = 0;
   endtask

   task automatic model_edge();
      bit          idle;
      bit          acc;
      bit          popped;
      bit          res_pend_pre;
      int          fsize;
      logic [31:0] w;
      idle         = (m_cur.size() == 0);
      acc          = !idle && u_if.tx_ready;
      popped       = 0;
      res_pend_pre = m_res_pend;
      fsize        = m_fifo.size();
      if (acc) begin
         void'(m_cur.pop_front());
         if (m_cur.size() == 0 && m_cur_res) m_res_pend = 0;
      end
      if (idle) begin
         if (m_res_pend && (fsize == 0 || m_last_print)) begin
            m_cur.push_back(m_res_byte);
            m_cur_res    = 1;
            m_last_print = 0;
         end else if (fsize != 0) begin
            w      = m_fifo.pop_front();
            popped = 1;
            for (int k = 0; k < 4; k++) m_cur.push_back(w[8*k +: 8]);
            m_cur_res    = 0;
            m_last_print = 1;
         end
      end
      if (u_if.print_en) begin
         if (fsize < DEPTH || popped) m_fifo.push_back(u_if.print_data);
         else                         m_ovf = 1;
      end
      if (u_if.res_req && !res_pend_pre) begin
         m_res_pend = 1;
         m_res_byte = u_if.res_byte;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      bit         ev;
      logic [7:0] ed;
      ev = (m_cur.size() != 0);
      ed = ev ? m_cur[0] : 8'h00;
      chk("tx_valid",   32'(u_if.tx_valid),   32'(ev));
      chk("tx_data",    32'(u_if.tx_data),    32'(ed));
      chk("res_ready",  32'(u_if.res_ready),  32'(!m_res_pend));
      chk("print_full", 32'(u_if.print_full), 32'(m_fifo.size() == DEPTH));
      chk("print_ovf",  32'(u_if.print_ovf),  32'(m_ovf));
      chk("busy",       32'(u_if.busy),       32'(ev || m_fifo.size() != 0 || m_res_pend));
   endtask

   task automatic cycle();
      @(negedge clk);
      check_outputs();
      if (rstn) model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      u_if.print_en = 1'b0;
      u_if.res_req  = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      u_if.res_req    = 1'b0;
      u_if.res_byte   = '0;
      u_if.print_en   = 1'b0;
      u_if.print_data = '0;
      u_if.tx_ready   = 1'b0;
      model_reset();
      run(2);
      rstn = 1'b1;

      // Single word, PHY always ready.
      u_if.tx_ready   = 1'b1;
      u_if.print_en   = 1'b1;
      u_if.print_data = 32'h44332211;
      cycle();
      quiet();
      run(8);

      // Response arrives while the third byte of a word is on the wire.
      u_if.print_en   = 1'b1;
      u_if.print_data = 32'hDDCCBBAA;
      cycle();
      quiet();
      for (int i = 0; i < 10 && m_cur.size() != 2; i++) cycle();
      u_if.res_req  = 1'b1;
      u_if.res_byte = 8'hA5;
      cycle();
      quiet();
      run(8);

      // Three queued words against a continuous response stream.
      u_if.tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         u_if.print_en   = 1'b1;
         u_if.print_data = $urandom;
         cycle();
      end
      quiet();
      u_if.tx_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         u_if.res_req  = 1'b1;
         u_if.res_byte = 8'($urandom);
         cycle();
      end
      quiet();
      run(10);

      // PHY stalled, FIFO overfilled, then released.
      u_if.tx_ready = 1'b0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         u_if.print_en   = 1'b1;
         u_if.print_data = $urandom;
         cycle();
      end
      quiet();
      run(2);
      u_if.tx_ready = 1'b1;
      run(50);

      // Reset in the middle of a word with more words queued.
      for (int i = 0; i < 3; i++) begin
         u_if.print_en   = 1'b1;
         u_if.print_data = $urandom;
         cycle();
      end
      quiet();
      for (int i = 0; i < 10 && m_cur.size() != 3; i++) cycle();
      rstn = 1'b0;
      #1;
      chk("rst_tx_valid",   32'(u_if.tx_valid),   32'd0);
      chk("rst_res_ready",  32'(u_if.res_ready),  32'd1);
      chk("rst_busy",       32'(u_if.busy),       32'd0);
      chk("rst_print_full", 32'(u_if.print_full), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      run(2);
      rstn = 1'b1;
      run(10);

      // Full FIFO receives a push in the cycle IDLE pops its head.
      u_if.tx_ready = 1'b0;
      for (int i = 0; i < 30 && m_fifo.size() < DEPTH; i++) begin
         u_if.print_en   = 1'b1;
         u_if.print_data = $urandom;
         cycle();
      end
      quiet();
      u_if.tx_ready = 1'b1;
      for (int i = 0; i < 20 && !(m_cur.size() == 0 && m_fifo.size() == DEPTH); i++) cycle();
      u_if.print_en   = 1'b1;
      u_if.print_data = 32'hCAFEF00D;
      cycle();
      quiet();
      chk("full_pop_push_full", 32'(u_if.print_full), 32'd1);
      chk("full_pop_push_ovf",  32'(u_if.print_ovf),  32'd0);
      run(50);

      // Randomized traffic, then drain.
      for (int i = 0; i < 400; i++) begin
         u_if.print_en   = ($urandom_range(0, 3) == 0);
         u_if.print_data = $urandom;
         u_if.res_req    = ($urandom_range(0, 4) == 0);
         u_if.res_byte   = 8'($urandom);
         u_if.tx_ready   = ($urandom_range(0, 3) != 0);
         cycle();
      end
      quiet();
      u_if.tx_ready = 1'b1;
      run(60);
      chk("drain_busy", 32'(u_if.busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
